fuzz_stim_misr: RTL

//  Drives the stimulus side of a fuzz-generated DUT (clk + packed inputs wire0..wire4) and compacts its packed y response.

---
 rtl/fuzz_stim_misr_pkg.sv | 35 +++
 rtl/fuzz_stim_misr_if.sv | 18 +
 rtl/fuzz_stim_misr_misr.sv | 55 +++++
 rtl/fuzz_stim_misr.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fuzz_stim_misr_pkg.sv
// Shared types and constants for the fuzz stimulus/MISR harness (package fuzz_stim_pkg).
// Optional build macro consumed by users of this package: FUZZ_EQUIV_CMP_EN.
package fuzz_stim_pkg;

  localparam int STIM_W     = 49;
  localparam int RESP_W     = 386;
  localparam int MISR_W     = 32;
  localparam int CNT_W      = 16;
  localparam int PIPE_DEPTH = 3;

  localparam logic [63:0]       LFSR_POLY = 64'hD800_0000_0000_0000;
  localparam logic [MISR_W-1:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [MISR_W-1:0] MISR_INIT = 32'hFFFF_FFFF;

  localparam int WIRE0_OFF = 0;
  localparam int WIRE1_OFF = 18;
  localparam int WIRE2_OFF = 27;
  localparam int WIRE3_OFF = 35;
  localparam int WIRE4_OFF = 38;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [10:0] wire4;
    logic [2:0]  wire3;
    logic [7:0]  wire2;
    logic [8:0]  wire1;
    logic [17:0] wire0;
  } stim_t;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 64'h0);
  endfunction

endpackage

// File: rtl/fuzz_stim_misr_if.sv
// Stimulus/response bus between the harness and one fuzz DUT copy.
// FUZZ_EQUIV_CMP_EN adds the response of a second DUT copy.
interface fuzz_stim_misr_if;
  import fuzz_stim_pkg::*;

  logic [STIM_W-1:0] stim;
  logic              stim_valid;
  logic [RESP_W-1:0] resp_in;
`ifdef FUZZ_EQUIV_CMP_EN
  logic [RESP_W-1:0] resp_b_in;

  modport master (output stim, output stim_valid, input resp_in, input resp_b_in);
  modport slave  (input stim, input stim_valid, output resp_in, output resp_b_in);
`else
  modport master (output stim, output stim_valid, input resp_in);
  modport slave  (input stim, input stim_valid, output resp_in);
`endif
endinterface

// File: rtl/fuzz_stim_misr_misr.sv
// Response compactor: XOR-folds the wide DUT response into 32 bits and
// feeds it into a CRC-32-polynomial MISR.
module fuzz_misr
  import fuzz_stim_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              init,
  input  logic [RESP_W-1:0] resp,
  output logic [MISR_W-1:0] sig
);

  localparam int CHUNKS = (RESP_W + MISR_W - 1) / MISR_W;
  localparam int PAD_W  = CHUNKS * MISR_W - RESP_W;

  logic [CHUNKS*MISR_W-1:0] resp_pad;
  logic [MISR_W-1:0]        chunk [CHUNKS];
  logic [MISR_W-1:0]        fold;
  logic [MISR_W-1:0]        sig_reg;
  logic [MISR_W-1:0]        sig_next;

  assign resp_pad = {{PAD_W{1'b0}}, resp};

  generate
    for (genvar gi = 0; gi < CHUNKS; gi++) begin : g_chunk
      assign chunk[gi] = resp_pad[gi*MISR_W +: MISR_W];
    end
  endgenerate

  always_comb begin
    fold = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      fold = fold ^ chunk[i];
    end
  end

  always_comb begin
    sig_next = {sig_reg[MISR_W-2:0], 1'b0} ^ (sig_reg[MISR_W-1] ? MISR_POLY : '0) ^ fold;
  end

  // init wins over en so a restart never folds a stale response in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_reg <= MISR_INIT;
    end else if (init) begin
      sig_reg <= MISR_INIT;
    end else if (en) begin
      sig_reg <= sig_next;
    end
  end

  assign sig = sig_reg;

endmodule

// File: rtl/fuzz_stim_misr.sv
// Fuzz harness stimulus generator + response MISR: FSM, 64-bit Galois LFSR, counters.
// Define FUZZ_EQUIV_CMP_EN to add a direct comparison against a second DUT copy.
module fuzz_stim_misr
  import fuzz_stim_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_vec,
  input  logic [31:0]           seed,
  fuzz_stim_misr_if.master      dut,
  output logic                  busy,
  output logic                  done,
  output logic [MISR_W-1:0]     signature,
`ifdef FUZZ_EQUIV_CMP_EN
  output logic                  mismatch,
  output logic [CNT_W-1:0]      fail_idx,
`endif
  output logic [CNT_W-1:0]      vec_cnt
);

  localparam int DC_W = $clog2(PIPE_DEPTH + 1);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(PIPE_DEPTH - 1);

  state_t                 state_reg, state_next;
  logic [63:0]            lfsr_reg;
  logic [CNT_W-1:0]       rem_reg;
  logic [CNT_W-1:0]       vec_cnt_reg;
  logic [DC_W-1:0]        drain_cnt_reg;
  logic [PIPE_DEPTH-1:0]  vpipe_reg;
  logic                   start_acc;
  logic                   resp_valid;
  logic                   stim_valid_c;
  stim_t                  stim_fields;

  assign start_acc  = (state_reg == IDLE) && start;
  assign resp_valid = vpipe_reg[PIPE_DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    stim_valid_c = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (num_vec != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        stim_valid_c = 1'b1;
        busy         = 1'b1;
        if (rem_reg == CNT_W'(1)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt_reg == DRAIN_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A zero seed would lock the LFSR, so it is promoted to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg    <= 64'h1;
      rem_reg     <= '0;
      vec_cnt_reg <= '0;
    end else if (start_acc) begin
      lfsr_reg    <= (seed == 32'h0) ? 64'h1 : {32'h0, seed};
      rem_reg     <= num_vec;
      vec_cnt_reg <= '0;
    end else if (state_reg == RUN) begin
      lfsr_reg <= lfsr_step(lfsr_reg);
      rem_reg  <= rem_reg - CNT_W'(1);
      if (vec_cnt_reg != '1) begin
        vec_cnt_reg <= vec_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt_reg <= '0;
    end else if (state_reg == DRAIN) begin
      drain_cnt_reg <= drain_cnt_reg + DC_W'(1);
    end else begin
      drain_cnt_reg <= '0;
    end
  end

  // Response-valid delay line mirrors the DUT's input-to-y latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe_reg[0] <= 1'b0;
    end else begin
      vpipe_reg[0] <= stim_valid_c;
    end
  end

  generate
    for (genvar gi = 1; gi < PIPE_DEPTH; gi++) begin : g_vpipe
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vpipe_reg[gi] <= 1'b0;
        end else begin
          vpipe_reg[gi] <= vpipe_reg[gi-1];
        end
      end
    end
  endgenerate

  assign stim_fields.wire0 = lfsr_reg[WIRE0_OFF +: 18];
  assign stim_fields.wire1 = lfsr_reg[WIRE1_OFF +: 9];
  assign stim_fields.wire2 = lfsr_reg[WIRE2_OFF +: 8];
  assign stim_fields.wire3 = lfsr_reg[WIRE3_OFF +: 3];
  assign stim_fields.wire4 = lfsr_reg[WIRE4_OFF +: 11];

  assign dut.stim_valid = stim_valid_c;
  assign dut.stim       = stim_valid_c ? stim_fields : '0;
  assign vec_cnt        = vec_cnt_reg;

  fuzz_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (resp_valid),
    .init  (start_acc),
    .resp  (dut.resp_in),
    .sig   (signature)
  );

`ifdef FUZZ_EQUIV_CMP_EN
  logic [CNT_W-1:0] resp_idx_reg;
  logic             mismatch_reg;
  logic [CNT_W-1:0] fail_idx_reg;

  // Only the first divergence is recorded; later ones keep the sticky flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_idx_reg <= '0;
      mismatch_reg <= 1'b0;
      fail_idx_reg <= '0;
    end else if (start_acc) begin
      resp_idx_reg <= '0;
      mismatch_reg <= 1'b0;
      fail_idx_reg <= '0;
    end else if (resp_valid) begin
      resp_idx_reg <= resp_idx_reg + CNT_W'(1);
      if ((dut.resp_in != dut.resp_b_in) && !mismatch_reg) begin
        mismatch_reg <= 1'b1;
        fail_idx_reg <= resp_idx_reg;
      end
    end
  end

  assign mismatch = mismatch_reg;
  assign fail_idx = fail_idx_reg;
`endif

endmodule
